// File: rtl/toggle_deser_rx_if.sv
// rtl/toggle_deser_rx_if.sv - serial line input and word output bundle for toggle_deser_rx
interface toggle_deser_rx_if #(
    parameter int WIDTH = 8
);
    logic             line_in;
    logic             line_en;
    logic             resync;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             locked;
    logic             overrun;

    modport master (
        output line_in, line_en, resync, dout_ready,
        input  dout, dout_valid, locked, overrun
    );

    modport slave (
        input  line_in, line_en, resync, dout_ready,
        output dout, dout_valid, locked, overrun
    );
endinterface

// File: rtl/toggle_deser_rx.sv
// rtl/toggle_deser_rx.sv - toggle-decoding deserialiser with sync hunt and valid/ready word output
module toggle_deser_rx #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] SYNC_PATTERN = WIDTH'(8'h7E)
) (
    input  logic             clk,
    input  logic             rst,
    toggle_deser_rx_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {HUNT, DATA} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sr, sr_n, sr_shift;
    logic [WIDTH-1:0] dout_r, dout_n;
    logic             prev_line, prev_n;
    logic             valid_r, valid_n;
    logic             ovr_r, ovr_n;
    logic             rx_bit;
    logic             complete;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            cnt       <= '0;
            sr        <= '0;
            prev_line <= 1'b0;
            dout_r    <= '0;
            valid_r   <= 1'b0;
            ovr_r     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sr        <= sr_n;
            prev_line <= prev_n;
            dout_r    <= dout_n;
            valid_r   <= valid_n;
            ovr_r     <= ovr_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sr_n     = sr;
        prev_n   = prev_line;
        dout_n   = dout_r;
        valid_n  = valid_r;
        ovr_n    = ovr_r;
        complete = 1'b0;
        rx_bit   = bus.line_in ^ prev_line;
        sr_shift = {sr[WIDTH-2:0], rx_bit};

        // Line history advances even on a resync edge so the next decode stays aligned.
        if (bus.line_en) begin
            prev_n = bus.line_in;
        end

        if (bus.resync) begin
            state_n = HUNT;
            cnt_n   = '0;
            sr_n    = '0;
            ovr_n   = 1'b0;
        end else if (bus.line_en) begin
            sr_n = sr_shift;
            if (state == HUNT) begin
                if (sr_shift == SYNC_PATTERN) begin
                    state_n = DATA;
                    cnt_n   = '0;
                end
            end else if (cnt == LAST) begin
                cnt_n    = '0;
                complete = 1'b1;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end

        if (complete) begin
            if (!valid_r || bus.dout_ready) begin
                dout_n  = sr_shift;
                valid_n = 1'b1;
            end else begin
                ovr_n = 1'b1;
            end
        end else if (valid_r && bus.dout_ready) begin
            valid_n = 1'b0;
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = valid_r;
    assign bus.locked     = (state == DATA);
    assign bus.overrun    = ovr_r;
endmodule

// File: doc/toggle_deser_rx.md
Name: toggle_deser_rx

Overview:
- Receive-side counterpart of the team's T-flip-flop toggle encoder. The encoder flips its line on every input 1 and holds it on every 0.
- This block recovers each bit as the XOR of the current and previous line samples.
- It hunts for a sync pattern, then deserialises decoded bits into WIDTH-bit words.
- Words are presented on a valid/ready output interface; the block sits between the serial link pin logic and the word-level consumer.

Parameters:
- WIDTH, 8, word width and sync-pattern width in bits (legal range 2..32).
- SYNC_PATTERN, 8'h7E, WIDTH-bit decoded pattern that marks frame start; compared MSB-first.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- line_in  input  1  toggle-encoded serial line, already synchronised to clk.
- line_en  input  1  sample strobe; line_in is consumed only in cycles where line_en=1.
- resync  input  1  synchronous request to drop lock and return to HUNT.
- dout  output  WIDTH  received word, MSB = first received bit.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid=1 and dout_ready=1 at a clk edge.
- locked  output  1  high while in DATA state.
- overrun  output  1  sticky flag: a completed word was dropped because the output was full.

Behaviour:
- Reset (rst=1, asynchronous):
  - prev_line=0, shift register=0, bit count=0, state=HUNT.
  - dout=0, dout_valid=0, locked=0, overrun=0.
  - Reset asserted mid-word or mid-handshake discards everything; the held word is lost without handshake.
- Decode: on an edge with line_en=1, bit = line_in XOR prev_line, then prev_line <= line_in.
  - prev_line updates on every line_en=1 edge, including a resync edge, so line history stays consistent.
- Shift: sr <= {sr[WIDTH-2:0], bit} on every accepted bit. Cycles with line_en=0 change nothing except handshake logic.
- State HUNT:
  - locked=0.
  - After each shift, if the new sr value equals SYNC_PATTERN: state <= DATA, bit count <= 0, locked=1 from the next cycle.
  - The sync word itself is never output.
- State DATA:
  - Each accepted bit increments bit count.
  - When bit count = WIDTH-1 and a bit is accepted, the word is complete: count wraps to 0 and the completed word is {sr[WIDTH-2:0], bit}.
  - There is no in-band sync detection in DATA; data bytes equal to SYNC_PATTERN are delivered as data.
- Word completion latency: the word is registered into dout on the edge that accepts its last bit, so dout_valid=1 is visible in the following cycle.
- Output register rules at a completion edge:
  - If dout_valid=0, load dout and set dout_valid=1.
  - If dout_valid=1 and dout_ready=1 in the same cycle, the old word is consumed and the new word is loaded; dout_valid stays 1 and overrun is unaffected.
  - If dout_valid=1 and dout_ready=0, the new word is dropped, dout is unchanged, and overrun <= 1.
- Handshake without completion: dout_valid=1 and dout_ready=1 gives dout_valid <= 0; dout holds its last value.
- Stability: dout is stable while dout_valid=1 and dout_ready=0.
- resync=1 at an edge:
  - state <= HUNT, bit count <= 0, sr <= 0, overrun <= 0.
  - resync has priority over a simultaneous line_en bit; that bit is not shifted and is not counted.
  - A pending dout/dout_valid is kept and may still be handshaken.
- overrun clears only on rst or resync.

Test Plan:
- Reset and idle: rst pulse, then line_in=0 with line_en=1 for 20 cycles -> all decoded bits are 0; locked=0, dout_valid=0, overrun=0, dout=0.
- Lock and one word:
  - Stimulus: toggle-encode bits 0111_1110 then 1010_0101 (MSB-first), line_en=1 every cycle, dout_ready=1.
  - Required: locked=1 from the cycle after the 8th sync bit; dout=8'hA5 with dout_valid=1 exactly one cycle after the 16th bit edge, for one cycle.
- Strobe gaps: same stream with line_en asserted every 3rd cycle, line_in held between strobes -> identical words; dout_valid rises one cycle after the strobe carrying the last data bit.
- Backpressure and overrun:
  - Stimulus: after lock, send 8'h3C and 8'hC3 back-to-back with dout_ready=0.
  - Required: dout=8'h3C held, overrun=1 after the 8'hC3 completion edge.
  - Then dout_ready=1 for one cycle -> dout_valid=0; overrun stays 1.
- Simultaneous consume and complete: dout_ready=1 exactly on the completion edge of word 8'h55 while 8'h3C is pending -> dout=8'h55, dout_valid stays 1, overrun=0.
- Resync and async reset:
  - Assert resync mid-word (after 4 data bits) together with line_en -> locked=0 next cycle, overrun=0; the next full frame (sync + 8'hF0) yields 8'hF0.
  - Assert rst asynchronously between clk edges while dout_valid=1 -> all outputs are 0 immediately, without waiting for clk.
